// File: rtl/reg_mux_rr.sv
// reg_mux_rr: registered N:1 data multiplexer with valid/ready on every port.
// Mode 0 selects the channel named by addr_i; mode 1 arbitrates round-robin
// over valid channels. The selected word is held in a one-entry output register.
// Optional feature: define MUX_PARITY_EN to add out_parity_o (= ^out_data_o).
module reg_mux_rr #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4,
    localparam int unsigned SEL_W   = $clog2(CHANNELS)
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         mode_i,
    input  logic [SEL_W-1:0]             addr_i,
    input  logic [CHANNELS*WIDTH-1:0]    in_data_i,
    input  logic [CHANNELS-1:0]          in_valid_i,
    output logic [CHANNELS-1:0]          in_ready_o,
    output logic [WIDTH-1:0]             out_data_o,
    output logic [SEL_W-1:0]             out_sel_o,
    output logic                         out_valid_o,
`ifdef MUX_PARITY_EN
    output logic                         out_parity_o,
`endif
    input  logic                         out_ready_i
);

    typedef enum logic [0:0] {StEmpty, StFull} state_e;

    localparam logic [SEL_W-1:0] LastCh = SEL_W'(CHANNELS - 1);

    state_e             state_q;
    logic [WIDTH-1:0]   data_q;
    logic [SEL_W-1:0]   sel_q;
    logic [SEL_W-1:0]   ptr_q;
`ifdef MUX_PARITY_EN
    logic               parity_q;
`endif

    logic               load;
    logic               gnt_valid;
    logic [SEL_W-1:0]   gnt_idx;
    logic [WIDTH-1:0]   gnt_data;
    int unsigned        rr_idx;

    // The output register may take a word when empty or when it is being drained.
    assign load = (state_q == StEmpty) || out_ready_i;

    // Grant selection: fixed address or round-robin search starting at ptr_q.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        rr_idx    = 0;
        if (mode_i) begin
            for (int unsigned k = 0; k < CHANNELS; k++) begin
                rr_idx = int'(ptr_q) + k;
                if (rr_idx >= CHANNELS) begin
                    rr_idx = rr_idx - CHANNELS;
                end
                if (!gnt_valid && in_valid_i[SEL_W'(rr_idx)]) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = SEL_W'(rr_idx);
                end
            end
        end else if (int'(addr_i) < CHANNELS) begin
            // Out-of-range addresses (non power-of-two CHANNELS) never grant.
            if (in_valid_i[addr_i]) begin
                gnt_valid = 1'b1;
                gnt_idx   = addr_i;
            end
        end
    end

    assign gnt_data = in_data_i[int'(gnt_idx)*WIDTH +: WIDTH];

    // One-hot ready to the granted producer; forced low during reset.
    always_comb begin
        in_ready_o = '0;
        if (!reset_i && load && gnt_valid) begin
            in_ready_o[gnt_idx] = 1'b1;
        end
    end

    // Output register FSM and round-robin pointer.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= StEmpty;
            data_q   <= '0;
            sel_q    <= '0;
            ptr_q    <= '0;
`ifdef MUX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else if (load) begin
            if (gnt_valid) begin
                state_q  <= StFull;
                data_q   <= gnt_data;
                sel_q    <= gnt_idx;
`ifdef MUX_PARITY_EN
                parity_q <= ^gnt_data;
`endif
                // Only round-robin transfers move the pointer.
                if (mode_i) begin
                    ptr_q <= (gnt_idx == LastCh) ? '0 : gnt_idx + 1'b1;
                end
            end else begin
                state_q <= StEmpty;
            end
        end
    end

    assign out_valid_o  = (state_q == StFull);
    assign out_data_o   = data_q;
    assign out_sel_o    = sel_q;
`ifdef MUX_PARITY_EN
    assign out_parity_o = parity_q;
`endif

endmodule

// File: tb/tb_reg_mux_rr.sv
// Directed testbench for reg_mux_rr: a 4-channel instance for the main tests and
// a 3-channel instance for out-of-range addressing and asynchronous reset.
module tb_reg_mux_rr;

    logic        clk;
    int          checks;
    int          errors;

    // 4-channel DUT (A)
    logic        reset_a;
    logic        mode_a;
    logic [1:0]  addr_a;
    logic [31:0] in_data_a;
    logic [3:0]  in_valid_a;
    logic [3:0]  in_ready_a;
    logic [7:0]  out_data_a;
    logic [1:0]  out_sel_a;
    logic        out_valid_a;
    logic        out_ready_a;
`ifdef MUX_PARITY_EN
    logic        out_parity_a;
    logic        out_parity_b;
`endif

    // 3-channel DUT (B)
    logic        reset_b;
    logic        mode_b;
    logic [1:0]  addr_b;
    logic [23:0] in_data_b;
    logic [2:0]  in_valid_b;
    logic [2:0]  in_ready_b;
    logic [7:0]  out_data_b;
    logic [1:0]  out_sel_b;
    logic        out_valid_b;
    logic        out_ready_b;

    reg_mux_rr #(.WIDTH(8), .CHANNELS(4)) u_dut_a (
        .clk_i       (clk),
        .reset_i     (reset_a),
        .mode_i      (mode_a),
        .addr_i      (addr_a),
        .in_data_i   (in_data_a),
        .in_valid_i  (in_valid_a),
        .in_ready_o  (in_ready_a),
        .out_data_o  (out_data_a),
        .out_sel_o   (out_sel_a),
        .out_valid_o (out_valid_a),
`ifdef MUX_PARITY_EN
        .out_parity_o(out_parity_a),
`endif
        .out_ready_i (out_ready_a)
    );

    reg_mux_rr #(.WIDTH(8), .CHANNELS(3)) u_dut_b (
        .clk_i       (clk),
        .reset_i     (reset_b),
        .mode_i      (mode_b),
        .addr_i      (addr_b),
        .in_data_i   (in_data_b),
        .in_valid_i  (in_valid_b),
        .in_ready_o  (in_ready_b),
        .out_data_o  (out_data_b),
        .out_sel_o   (out_sel_b),
        .out_valid_o (out_valid_b),
`ifdef MUX_PARITY_EN
        .out_parity_o(out_parity_b),
`endif
        .out_ready_i (out_ready_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch_a(input int ch, input logic [7:0] val);
        in_data_a[ch*8 +: 8] = val;
    endtask

    task automatic set_ch_b(input int ch, input logic [7:0] val);
        in_data_b[ch*8 +: 8] = val;
    endtask

    task automatic test_reset();
        reset_a = 1'b1; reset_b = 1'b1;
        mode_a = 1'b0; addr_a = 2'd0; in_data_a = '0; in_valid_a = 4'b1111; out_ready_a = 1'b1;
        mode_b = 1'b0; addr_b = 2'd0; in_data_b = '0; in_valid_b = 3'b000;  out_ready_b = 1'b1;
        tick();
        tick();
        checks++;
        if (in_ready_a !== 4'b0000) begin
            errors++; $display("FAIL reset_in_ready got %b want 0000", in_ready_a);
        end
        checks++;
        if (out_valid_a !== 1'b0 || out_data_a !== 8'h00 || out_sel_a !== 2'd0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b d=%h s=%0d want v=0 d=00 s=0",
                     out_valid_a, out_data_a, out_sel_a);
        end
        in_valid_a = 4'b0000;
        reset_a = 1'b0; reset_b = 1'b0;
        tick();
        checks++;
        if (out_valid_a !== 1'b0) begin
            errors++; $display("FAIL reset_idle_valid got %b want 0", out_valid_a);
        end
    endtask

    task automatic test_fixed();
        mode_a = 1'b0; addr_a = 2'd2; out_ready_a = 1'b1;
        set_ch_a(2, 8'hA5); set_ch_a(0, 8'h11);
        in_valid_a = 4'b0101;
        #1;
        checks++;
        if (in_ready_a !== 4'b0100) begin
            errors++; $display("FAIL fixed_in_ready got %b want 0100", in_ready_a);
        end
        tick();
        checks++;
        if (out_valid_a !== 1'b1 || out_data_a !== 8'hA5 || out_sel_a !== 2'd2) begin
            errors++;
            $display("FAIL fixed_output got v=%b d=%h s=%0d want v=1 d=a5 s=2",
                     out_valid_a, out_data_a, out_sel_a);
        end
        // Addressed channel not valid: no grant even though others are valid.
        in_valid_a = 4'b1011;
        #1;
        checks++;
        if (in_ready_a !== 4'b0000) begin
            errors++; $display("FAIL fixed_addr_invalid got %b want 0000", in_ready_a);
        end
        tick();
        checks++;
        if (out_valid_a !== 1'b0 || out_data_a !== 8'hA5 || out_sel_a !== 2'd2) begin
            errors++;
            $display("FAIL fixed_drain got v=%b d=%h s=%0d want v=0 d=a5 s=2",
                     out_valid_a, out_data_a, out_sel_a);
        end
        in_valid_a = 4'b0000;
    endtask

    // ptr is still 0 (fixed transfers do not move it): expect 0,1,2,3,0.
    task automatic test_rr_full();
        logic [1:0] exp_sel [5];
        exp_sel = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        mode_a = 1'b1; out_ready_a = 1'b1;
        for (int i = 0; i < 4; i++) set_ch_a(i, 8'h10 + 8'(i));
        in_valid_a = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (in_ready_a !== (4'b0001 << exp_sel[i])) begin
                errors++;
                $display("FAIL rr_in_ready[%0d] got %b want %b", i, in_ready_a,
                         4'b0001 << exp_sel[i]);
            end
            tick();
            checks++;
            if (out_valid_a !== 1'b1 || out_sel_a !== exp_sel[i]
                || out_data_a !== 8'h10 + 8'(exp_sel[i])) begin
                errors++;
                $display("FAIL rr_output[%0d] got v=%b s=%0d d=%h want v=1 s=%0d d=%h", i,
                         out_valid_a, out_sel_a, out_data_a, exp_sel[i],
                         8'h10 + 8'(exp_sel[i]));
            end
        end
        in_valid_a = 4'b0000;
        tick();
    endtask

    // ptr = 1 after the last grant of channel 0: expect 3, 0, 3.
    task automatic test_rr_sparse();
        logic [1:0] exp_sel [3];
        exp_sel = '{2'd3, 2'd0, 2'd3};
        mode_a = 1'b1; out_ready_a = 1'b1;
        set_ch_a(0, 8'hC0); set_ch_a(3, 8'hC3);
        in_valid_a = 4'b1001;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (out_valid_a !== 1'b1 || out_sel_a !== exp_sel[i]) begin
                errors++;
                $display("FAIL rr_sparse[%0d] got v=%b s=%0d want v=1 s=%0d", i,
                         out_valid_a, out_sel_a, exp_sel[i]);
            end
        end
        in_valid_a = 4'b0000;
        tick();
    endtask

    task automatic test_backpressure();
        mode_a = 1'b0; addr_a = 2'd1; out_ready_a = 1'b1;
        set_ch_a(1, 8'h3C);
        in_valid_a = 4'b0010;
        tick();
        out_ready_a = 1'b0;
        set_ch_a(1, 8'h5A);
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (in_ready_a !== 4'b0000) begin
                errors++; $display("FAIL bp_in_ready[%0d] got %b want 0000", i, in_ready_a);
            end
            tick();
            checks++;
            if (out_valid_a !== 1'b1 || out_data_a !== 8'h3C) begin
                errors++;
                $display("FAIL bp_hold[%0d] got v=%b d=%h want v=1 d=3c", i,
                         out_valid_a, out_data_a);
            end
        end
        out_ready_a = 1'b1;
        #1;
        checks++;
        if (in_ready_a !== 4'b0010) begin
            errors++; $display("FAIL bp_release_ready got %b want 0010", in_ready_a);
        end
        tick();
        checks++;
        if (out_valid_a !== 1'b1 || out_data_a !== 8'h5A || out_sel_a !== 2'd1) begin
            errors++;
            $display("FAIL bp_replace got v=%b d=%h s=%0d want v=1 d=5a s=1",
                     out_valid_a, out_data_a, out_sel_a);
        end
        in_valid_a = 4'b0000;
        tick();
    endtask

    // ptr is 0 after the sparse test's final grant of 3; fixed transfers left it alone.
    task automatic test_mode_switch();
        mode_a = 1'b1; out_ready_a = 1'b1;
        in_valid_a = 4'b1111;
        #1;
        checks++;
        if (in_ready_a !== 4'b0001) begin
            errors++; $display("FAIL mode_switch_ptr got %b want 0001", in_ready_a);
        end
        tick();
        in_valid_a = 4'b0000;
        tick();
    endtask

    task automatic test_out_of_range();
        mode_b = 1'b0; addr_b = 2'd3; out_ready_b = 1'b1;
        set_ch_b(0, 8'h70); set_ch_b(1, 8'h77); set_ch_b(2, 8'h72);
        in_valid_b = 3'b111;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (in_ready_b !== 3'b000) begin
                errors++; $display("FAIL oor_in_ready[%0d] got %b want 000", i, in_ready_b);
            end
            tick();
            checks++;
            if (out_valid_b !== 1'b0) begin
                errors++; $display("FAIL oor_valid[%0d] got %b want 0", i, out_valid_b);
            end
        end
        addr_b = 2'd1;
        tick();
        checks++;
        if (out_valid_b !== 1'b1 || out_data_b !== 8'h77 || out_sel_b !== 2'd1) begin
            errors++;
            $display("FAIL oor_inrange got v=%b d=%h s=%0d want v=1 d=77 s=1",
                     out_valid_b, out_data_b, out_sel_b);
        end
        // Asynchronous reset mid-cycle while FULL.
        out_ready_b = 1'b0;
        #2;
        reset_b = 1'b1;
        #1;
        checks++;
        if (out_valid_b !== 1'b0 || out_data_b !== 8'h00 || out_sel_b !== 2'd0
            || in_ready_b !== 3'b000) begin
            errors++;
            $display("FAIL async_reset got v=%b d=%h s=%0d r=%b want v=0 d=00 s=0 r=000",
                     out_valid_b, out_data_b, out_sel_b, in_ready_b);
        end
        tick();
        reset_b = 1'b0;
        in_valid_b = 3'b000;
        tick();
    endtask

`ifdef MUX_PARITY_EN
    task automatic test_parity();
        mode_a = 1'b0; addr_a = 2'd0; out_ready_a = 1'b1;
        set_ch_a(0, 8'h07);
        in_valid_a = 4'b0001;
        tick();
        checks++;
        if (out_parity_a !== 1'b1) begin
            errors++; $display("FAIL parity_07 got %b want 1", out_parity_a);
        end
        set_ch_a(0, 8'h03);
        tick();
        checks++;
        if (out_parity_a !== 1'b0) begin
            errors++; $display("FAIL parity_03 got %b want 0", out_parity_a);
        end
        in_valid_a = 4'b0000;
        tick();
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_fixed();
        test_rr_full();
        test_rr_sparse();
        test_backpressure();
        test_mode_switch();
        test_out_of_range();
`ifdef MUX_PARITY_EN
        test_parity();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
